imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Sequences and shares the single port of the byte-addressed instruction memory between two requesters: the fetch stage (word reads) and the program loader (word writes).
- Fetch has priority. A starvation counter guarantees loader progress.
- Memory has a fixed access latency. Each transaction is a word: four bytes, big-endian, starting at the aligned address.
- Sits between the IF stage / loader and the instruction memory.

Parameters:
- PCL, 32, address width in bits.
- MEM_LAT, 2, memory access cycles per transaction (≥1).
- STARVE_MAX, 4, consecutive fetch grants allowed while the loader waits (≥1).
- NOP, 32'h0400_0000, value driven on f_rdata at reset and for dropped fetches.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held until f_gnt.
- f_addr  in  PCL  fetch byte address.
- f_gnt  out  1  fetch granted (combinational, IDLE only).
- f_rvalid  out  1  one-cycle pulse; f_rdata valid.
- f_rdata  out  32  fetched word.
- f_misalign  out  1  pulses with f_rvalid when the granted f_addr[1:0]≠0.
- l_req  in  1  loader write request; held until l_gnt.
- l_addr  in  PCL  loader byte address.
- l_wdata  in  32  loader write word.
- l_gnt  out  1  loader granted (combinational, IDLE only).
- l_done  out  1  one-cycle pulse; write completed.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  PCL  word-aligned memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; valid in the last ACCESS cycle.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, starve_cnt=0.
  - f_rvalid, l_done, f_misalign, m_en, m_we = 0.
  - m_addr=0, m_wdata=0, f_rdata=NOP.
  - An in-flight transaction is dropped with no response; requesters re-issue.
- IDLE arbitration:
  - f_req only → fetch wins. l_req only → loader wins.
  - Both → fetch wins unless starve_cnt==STARVE_MAX, then loader wins.
  - Winner's gnt=1 that cycle. The loser's gnt=0.
- IDLE, on a grant (edge):
  - Latch m_addr = {addr[PCL-1:2],2'b00}.
  - Latch m_we (1 for loader), m_wdata (l_wdata for loader, else held), owner, misalign flag.
  - cnt=MEM_LAT-1; go to ACCESS.
- starve_cnt update at each grant:
  - Loader grant → 0.
  - Fetch grant with l_req=1 → starve_cnt+1, saturating at STARVE_MAX.
  - Fetch grant with l_req=0 → 0.
- ACCESS:
  - m_en=1 and m_we=latched for every ACCESS cycle (MEM_LAT cycles). m_addr and m_wdata stable.
  - cnt decrements each cycle.
  - At cnt==0 (edge): a fetch captures m_rdata into f_rdata. Go to RESP.
- RESP (one cycle):
  - m_en=0, m_we=0.
  - Fetch owner → f_rvalid=1, f_misalign=latched flag. Loader owner → l_done=1.
  - Next state IDLE. No grant is issued in RESP.
- Timing:
  - Grant in cycle G → ACCESS cycles G+1..G+MEM_LAT → response in cycle G+MEM_LAT+1.
  - Throughput: one transaction per MEM_LAT+2 cycles.
- Between grants, f_rdata holds its last value.
- Requests that arrive while not in IDLE wait. No queue exists beyond the requester holding req.
- Address wrap: the address is used as given, so an aligned top word is valid. No increment is performed.

Test Plan:
- Reset then f_req=1, f_addr=0x10, MEM_LAT=2, m_rdata=0x8C01_0004 → f_gnt in cycle 0, m_en cycles 1–2 with m_addr=0x10, f_rvalid and f_rdata=0x8C01_0004 in cycle 3. Before any fetch, f_rdata=0x0400_0000.
- l_req=1, l_addr=0x20, l_wdata=0xDEAD_BEEF → l_gnt, then m_en=m_we=1 for 2 cycles with m_wdata=0xDEAD_BEEF, then l_done pulse. f_rvalid stays 0.
- f_req and l_req held continuously, STARVE_MAX=4 → grant order F,F,F,F,L,F,F,F,F,L. No grant ever issued in ACCESS or RESP.
- f_addr=0x13 → m_addr=0x10; f_rvalid and f_misalign=1 together. Following aligned fetch has f_misalign=0.
- rst pulled low in the second ACCESS cycle of a fetch → all outputs zero and f_rdata=NOP immediately. After release, no f_rvalid appears; a re-issued f_req completes normally.
- MEM_LAT=1, back-to-back fetches → f_rvalid every 3 cycles.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares the instruction memory port between fetch (reads) and loader (writes)
module imem_port_arbiter #(
  parameter int          PCL        = 32,
  parameter int          MEM_LAT    = 2,
  parameter int          STARVE_MAX = 4,
  parameter logic [31:0] NOP        = 32'h0400_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           f_req,
  input  logic [PCL-1:0] f_addr,
  output logic           f_gnt,
  output logic           f_rvalid,
  output logic [31:0]    f_rdata,
  output logic           f_misalign,
  input  logic           l_req,
  input  logic [PCL-1:0] l_addr,
  input  logic [31:0]    l_wdata,
  output logic           l_gnt,
  output logic           l_done,
  output logic           m_en,
  output logic           m_we,
  output logic [PCL-1:0] m_addr,
  output logic [31:0]    m_wdata,
  input  logic [31:0]    m_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_l;
  logic          we_q;
  logic          mis_q;
  logic          grant_f;
  logic          grant_l;

  // Loader writes are always word-aligned, so its low address bits carry no meaning.
  logic unused_l_addr;
  assign unused_l_addr = &{1'b0, l_addr[1:0]};

  always_comb begin
    grant_f  = 1'b0;
    grant_l  = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        if (f_req && !(l_req && starve_cnt == STARVE_LIM)) begin
          grant_f = 1'b1;
        end else if (l_req) begin
          grant_l = 1'b1;
        end
        if (grant_f || grant_l) begin
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grants are masked while reset is held so every output is quiet during reset.
  assign f_gnt      = grant_f & rst;
  assign l_gnt      = grant_l & rst;
  assign m_en       = (state == ACCESS);
  assign m_we       = (state == ACCESS) & we_q;
  assign f_rvalid   = (state == RESP) & ~owner_l;
  assign f_misalign = (state == RESP) & ~owner_l & mis_q;
  assign l_done     = (state == RESP) & owner_l;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      owner_l    <= 1'b0;
      we_q       <= 1'b0;
      mis_q      <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      f_rdata    <= NOP;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant_l) begin
            m_addr     <= {l_addr[PCL-1:2], 2'b00};
            m_wdata    <= l_wdata;
            we_q       <= 1'b1;
            owner_l    <= 1'b1;
            mis_q      <= 1'b0;
            cnt        <= CNT_INIT;
            starve_cnt <= '0;
          end else if (grant_f) begin
            m_addr     <= {f_addr[PCL-1:2], 2'b00};
            we_q       <= 1'b0;
            owner_l    <= 1'b0;
            mis_q      <= |f_addr[1:0];
            cnt        <= CNT_INIT;
            if (!l_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!owner_l) begin
            f_rdata <= m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed bench for imem_port_arbiter (MEM_LAT=2 and MEM_LAT=1 instances)
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        f_req, f_gnt, f_rvalid, f_misalign, l_req, l_gnt, l_done, m_en, m_we;
  logic [31:0] f_addr, f_rdata, l_addr, l_wdata, m_addr, m_wdata, m_rdata;

  logic        f_req1, f_gnt1, f_rvalid1, f_misalign1, l_req1, l_gnt1, l_done1, m_en1, m_we1;
  logic [31:0] f_addr1, f_rdata1, l_addr1, l_wdata1, m_addr1, m_wdata1, m_rdata1;

  imem_port_arbiter #(.PCL(32), .MEM_LAT(2), .STARVE_MAX(4), .NOP(32'h0400_0000)) u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_misalign(f_misalign),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_done(l_done),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  imem_port_arbiter #(.PCL(32), .MEM_LAT(1), .STARVE_MAX(4), .NOP(32'h0400_0000)) u_dut1 (
    .clk(clk), .rst(rst),
    .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1), .f_rvalid(f_rvalid1),
    .f_rdata(f_rdata1), .f_misalign(f_misalign1),
    .l_req(l_req1), .l_addr(l_addr1), .l_wdata(l_wdata1), .l_gnt(l_gnt1), .l_done(l_done1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Entered and left at the start of an IDLE cycle; expects grant, two ACCESS cycles, then RESP.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic mis, input string tag);
    logic [31:0] wa;
    wa      = {a[31:2], 2'b00};
    f_req   = 1'b1;
    f_addr  = a;
    m_rdata = d;
    smp(); chk({tag, "_fgnt"}, {31'd0, f_gnt}, 32'd1);
    cyc(); f_req = 1'b0;
    smp(); chk({tag, "_maddr"}, m_addr, wa);
           chk({tag, "_men1"}, {31'd0, m_en}, 32'd1);
    cyc();
    smp(); chk({tag, "_men2"}, {31'd0, m_en}, 32'd1);
    cyc();
    smp(); chk({tag, "_rvalid"}, {31'd0, f_rvalid}, 32'd1);
           chk({tag, "_mis"}, {31'd0, f_misalign}, {31'd0, mis});
           chk({tag, "_rdata"}, f_rdata, d);
           chk({tag, "_men_resp"}, {31'd0, m_en}, 32'd0);
    cyc();
  endtask

  initial begin
    int          ng, viol, nrv, n;
    logic [9:0]  seq;
    int          t[8];

    rst = 1'b0;
    f_req = 0; f_addr = 0; l_req = 0; l_addr = 0; l_wdata = 0; m_rdata = 0;
    f_req1 = 0; f_addr1 = 0; l_req1 = 0; l_addr1 = 0; l_wdata1 = 0; m_rdata1 = 0;
    cyc(); cyc();
    smp();
    chk("rst_frdata", f_rdata, 32'h0400_0000);
    chk("rst_men", {31'd0, m_en}, 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_rvalid", {31'd0, f_rvalid}, 32'd0);
    chk("rst_frdata1", f_rdata1, 32'h0400_0000);
    cyc(); rst = 1'b1;
    cyc();

    do_fetch(32'h10, 32'h8C01_0004, 1'b0, "t1");
    smp(); chk("t1_rvalid_off", {31'd0, f_rvalid}, 32'd0);
           chk("t1_rdata_hold", f_rdata, 32'h8C01_0004);
    cyc();

    l_req = 1'b1; l_addr = 32'h20; l_wdata = 32'hDEAD_BEEF;
    smp(); chk("t2_lgnt", {31'd0, l_gnt}, 32'd1);
           chk("t2_fgnt", {31'd0, f_gnt}, 32'd0);
    cyc(); l_req = 1'b0;
    smp(); chk("t2_men", {31'd0, m_en}, 32'd1);
           chk("t2_mwe", {31'd0, m_we}, 32'd1);
           chk("t2_mwdata", m_wdata, 32'hDEAD_BEEF);
           chk("t2_maddr", m_addr, 32'h20);
    cyc();
    smp(); chk("t2_mwe2", {31'd0, m_we}, 32'd1);
    cyc();
    smp(); chk("t2_ldone", {31'd0, l_done}, 32'd1);
           chk("t2_rvalid", {31'd0, f_rvalid}, 32'd0);
           chk("t2_mwe_resp", {31'd0, m_we}, 32'd0);
    cyc();
    smp(); chk("t2_ldone_off", {31'd0, l_done}, 32'd0);
    cyc();

    do_fetch(32'h13, 32'h1111_2222, 1'b1, "t3");
    do_fetch(32'h14, 32'h3333_4444, 1'b0, "t3b");

    f_req = 1'b1; l_req = 1'b1; f_addr = 32'h40; l_addr = 32'h80; l_wdata = 32'h0BAD_F00D;
    ng = 0; viol = 0; seq = '0;
    for (int c = 0; c < 80 && ng < 10; c++) begin
      smp();
      if (f_gnt && l_gnt) viol++;
      if ((f_gnt || l_gnt) && (m_en || f_rvalid || l_done)) viol++;
      if (f_gnt || l_gnt) begin
        seq = {seq[8:0], l_gnt};
        ng++;
      end
      cyc();
    end
    f_req = 1'b0; l_req = 1'b0;
    chk("t4_ngrants", ng, 32'd10);
    chk("t4_order", {22'd0, seq}, {22'd0, 10'b00001_00001});
    chk("t4_viol", viol, 32'd0);
    cyc(); cyc(); cyc();

    f_req = 1'b1; f_addr = 32'h30; m_rdata = 32'h5555_6666;
    smp(); chk("t5_fgnt", {31'd0, f_gnt}, 32'd1);
    cyc(); f_req = 1'b0;
    cyc(); f_req = 1'b1; rst = 1'b0;
    smp(); chk("t5_men", {31'd0, m_en}, 32'd0);
           chk("t5_mwe", {31'd0, m_we}, 32'd0);
           chk("t5_maddr", m_addr, 32'd0);
           chk("t5_mwdata", m_wdata, 32'd0);
           chk("t5_frdata", f_rdata, 32'h0400_0000);
           chk("t5_rvalid", {31'd0, f_rvalid}, 32'd0);
           chk("t5_fgnt_rst", {31'd0, f_gnt}, 32'd0);
    cyc(); rst = 1'b1; f_req = 1'b0;
    nrv = 0;
    for (int c = 0; c < 4; c++) begin
      smp();
      if (f_rvalid) nrv++;
      cyc();
    end
    chk("t5_no_rvalid", nrv, 32'd0);
    do_fetch(32'h30, 32'h5555_6666, 1'b0, "t5r");

    f_req1 = 1'b1; f_addr1 = 32'h100; m_rdata1 = 32'hA5A5_0001;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      smp();
      if (f_rvalid1 && n < 8) begin
        t[n] = c;
        n++;
      end
      cyc();
    end
    f_req1 = 1'b0;
    chk("t6_npulses", n, 32'd6);
    chk("t6_first", t[0], 32'd2);
    chk("t6_second", t[1], 32'd5);
    chk("t6_third", t[2], 32'd8);
    chk("t6_rdata", f_rdata1, 32'hA5A5_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
